// File: rtl/ktms_fc_cnttbl_if.sv
// Handshake/bus bundle for the FC per-ID credit counter table (ktms_fc_cnttbl).
// The slave modport is the table; the master modport is the command-path client.
interface ktms_fc_cnttbl_if #(
  parameter int id_width  = 1,
  parameter int amt_width = 4
);
  // Valid/ready: a request transfers on a rising clk edge where both v and r are 1.
  // A requester that sees r=0 keeps v, id and amt stable until the transfer happens.
  logic                 i_inc_v;
  logic                 i_inc_r;
  logic [id_width-1:0]  i_inc_id;
  logic [amt_width-1:0] i_inc_amt;
  logic                 i_dec_v;
  logic                 i_dec_r;
  logic [id_width-1:0]  i_dec_id;
  logic [amt_width-1:0] i_dec_amt;
  logic [id_width-1:0]  i_rd_a;
  logic                 o_rd_z;
  logic                 o_init_done;
  logic                 o_err_v;
  logic                 o_err_ovf;
  logic [id_width-1:0]  o_err_id;

  modport slave (
    input  i_inc_v, i_inc_id, i_inc_amt,
    input  i_dec_v, i_dec_id, i_dec_amt,
    input  i_rd_a,
    output i_inc_r, i_dec_r,
    output o_rd_z, o_init_done, o_err_v, o_err_ovf, o_err_id
  );

  modport master (
    output i_inc_v, i_inc_id, i_inc_amt,
    output i_dec_v, i_dec_id, i_dec_amt,
    output i_rd_a,
    input  i_inc_r, i_dec_r,
    input  o_rd_z, o_init_done, o_err_v, o_err_ovf, o_err_id
  );
endinterface

// File: rtl/ktms_fc_cnttbl.sv
// Per-ID outstanding-credit counter table: 2-stage read/modify/write with s2->s1 bypass,
// post-reset clear sweep, saturate/clamp with error report. Option macro: KTMS_FC_CNTTBL_ERRHOLD_EN.
module ktms_fc_cnttbl #(
  parameter int id_width  = 1,
  parameter int width     = 8,
  parameter int amt_width = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  ktms_fc_cnttbl_if.slave    bus,
  output logic               o_dbg_state
);

  localparam int DEPTH = 1 << id_width;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [id_width-1:0]  sweep_q, sweep_d;

  logic [width-1:0]     cnt_q [DEPTH];

  logic                 s2_v_q;
  logic [id_width-1:0]  s2_id_q;
  logic [amt_width-1:0] s2_inc_q, s2_dec_q;
  logic [width-1:0]     s2_cnt_q;

  logic [DEPTH-1:0]     nz_q, nz_d;

  logic                 err_v_q, err_v_d;
  logic                 err_ovf_q, err_ovf_d;
  logic [id_width-1:0]  err_id_q, err_id_d;

  logic                 run;
  logic                 inc_xfer, dec_xfer;
  logic                 s1_v;
  logic [id_width-1:0]  s1_id;
  logic [amt_width-1:0] s1_inc, s1_dec;
  logic [width-1:0]     s1_rd;

  logic [width+1:0]     sum;
  logic                 s2_ovf, s2_unf, s2_err;
  logic [width-1:0]     s2_res;

  // Init FSM: walk every entry once writing zero, then serve requests.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == S_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == {id_width{1'b1}}) begin
        state_d = S_RUN;
      end
    end
  end

  assign run         = (state_q == S_RUN);
  assign o_dbg_state = logic'(state_q);

  assign bus.i_inc_r = run;
  // Only differing IDs collide; same-ID inc+dec is merged into one pipeline op.
  assign bus.i_dec_r = run & ~(bus.i_inc_v & bus.i_dec_v & (bus.i_inc_id != bus.i_dec_id));

  assign inc_xfer = bus.i_inc_v & bus.i_inc_r;
  assign dec_xfer = bus.i_dec_v & bus.i_dec_r;

  always_comb begin
    s1_v   = inc_xfer | dec_xfer;
    s1_id  = inc_xfer ? bus.i_inc_id : bus.i_dec_id;
    s1_inc = inc_xfer ? bus.i_inc_amt : '0;
    s1_dec = dec_xfer ? bus.i_dec_amt : '0;
    s1_rd  = (s2_v_q && (s2_id_q == s1_id)) ? s2_res : cnt_q[s1_id];
  end

  // Two guard bits: bit width flags overflow, bit width+1 flags a negative result.
  always_comb begin
    sum    = {2'b00, s2_cnt_q}
           + {{(width + 2 - amt_width){1'b0}}, s2_inc_q}
           - {{(width + 2 - amt_width){1'b0}}, s2_dec_q};
    s2_unf = sum[width+1];
    s2_ovf = ~sum[width+1] & sum[width];
    s2_err = s2_v_q & (s2_ovf | s2_unf);
    if (s2_unf) begin
      s2_res = '0;
    end else if (s2_ovf) begin
      s2_res = '1;
    end else begin
      s2_res = sum[width-1:0];
    end
  end

  // Clear first, then early set, so a same-cycle inc to the same ID keeps the flag up.
  always_comb begin
    nz_d = nz_q;
    if (s2_v_q && (s2_res == '0)) begin
      nz_d[s2_id_q] = 1'b0;
    end
    if (inc_xfer && (bus.i_inc_amt != '0)) begin
      nz_d[bus.i_inc_id] = 1'b1;
    end
  end

  always_comb begin
    err_v_d   = err_v_q;
    err_ovf_d = err_ovf_q;
    err_id_d  = err_id_q;
`ifdef KTMS_FC_CNTTBL_ERRHOLD_EN
    if (!err_v_q && s2_err) begin
      err_v_d   = 1'b1;
      err_ovf_d = s2_ovf;
      err_id_d  = s2_id_q;
    end
`else
    err_v_d = s2_err;
    if (s2_err) begin
      err_ovf_d = s2_ovf;
      err_id_d  = s2_id_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      sweep_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_id_q   <= '0;
      s2_inc_q  <= '0;
      s2_dec_q  <= '0;
      s2_cnt_q  <= '0;
      nz_q      <= '0;
      err_v_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      err_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      s2_v_q    <= s1_v;
      s2_id_q   <= s1_id;
      s2_inc_q  <= s1_inc;
      s2_dec_q  <= s1_dec;
      s2_cnt_q  <= s1_rd;
      nz_q      <= nz_d;
      err_v_q   <= err_v_d;
      err_ovf_q <= err_ovf_d;
      err_id_q  <= err_id_d;
    end
  end

  // Counter storage is RAM-like (no reset); the init sweep provides the cleared state.
  always_ff @(posedge clk) begin
    if (!run) begin
      cnt_q[sweep_q] <= '0;
    end else if (s2_v_q) begin
      cnt_q[s2_id_q] <= s2_res;
    end
  end

  assign bus.o_rd_z      = ~nz_q[bus.i_rd_a];
  assign bus.o_init_done = run;
  assign bus.o_err_v     = err_v_q;
  assign bus.o_err_ovf   = err_ovf_q;
  assign bus.o_err_id    = err_id_q;

endmodule

// File: tb/tb_ktms_fc_cnttbl.sv
// Directed bench for ktms_fc_cnttbl (id_width=2, width=8, amt_width=4), default build.
module tb_ktms_fc_cnttbl;

  logic clk;
  logic reset_n;
  logic dbg_state;

  int compared   = 0;
  int mismatched = 0;

  // Expected error reports, {ovf, id}, pushed when the erring op is issued.
  logic [2:0] exp_q[$];

  ktms_fc_cnttbl_if #(.id_width(2), .amt_width(4)) bus ();

  ktms_fc_cnttbl #(.id_width(2), .width(8), .amt_width(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_z(input logic [3:0] exp_z);
    for (int i = 0; i < 4; i++) begin
      bus.i_rd_a = 2'(i);
      #1;
      check($sformatf("rd_z[%0d]", i), 32'(bus.o_rd_z), 32'(exp_z[i]));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.o_err_v === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL err_unexpected: got ovf=%0b id=%0d expected no error at %0t",
                 bus.o_err_ovf, bus.o_err_id, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check("err_report", 32'({bus.o_err_ovf, bus.o_err_id}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [1:0] iid, input logic [3:0] iamt,
                       input logic dv, input logic [1:0] did, input logic [3:0] damt,
                       input logic exp_dr);
    bus.i_inc_v   = iv;
    bus.i_inc_id  = iid;
    bus.i_inc_amt = iamt;
    bus.i_dec_v   = dv;
    bus.i_dec_id  = did;
    bus.i_dec_amt = damt;
    @(negedge clk);
    if (iv) check("inc_r", 32'(bus.i_inc_r), 32'd1);
    if (dv) check("dec_r", 32'(bus.i_dec_r), 32'(exp_dr));
    @(posedge clk);
    #1;
    bus.i_inc_v = 1'b0;
    bus.i_dec_v = 1'b0;
  endtask

  task automatic idle();
    bus.i_inc_v = 1'b0;
    bus.i_dec_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic release_and_sweep();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("init_done_clk%0d", k), 32'(bus.o_init_done), (k == 4) ? 32'd1 : 32'd0);
      check_all_z(4'b1111);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n       = 1'b0;
    bus.i_inc_v   = 1'b0;
    bus.i_inc_id  = '0;
    bus.i_inc_amt = '0;
    bus.i_dec_v   = 1'b0;
    bus.i_dec_id  = '0;
    bus.i_dec_amt = '0;
    bus.i_rd_a    = '0;

    #3;
    check("rst_init_done", 32'(bus.o_init_done), 32'd0);
    check("rst_inc_r", 32'(bus.i_inc_r), 32'd0);
    check("rst_dec_r", 32'(bus.i_dec_r), 32'd0);
    check("rst_err_v", 32'(bus.o_err_v), 32'd0);
    check_all_z(4'b1111);

    release_and_sweep();

    // inc id1 by 3, then three back-to-back dec by 1
    drive(1'b1, 2'd1, 4'd3, 1'b0, 2'd0, 4'd0, 1'b1);
    check_all_z(4'b1101);
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 4'd1, 1'b1);
      check_all_z(4'b1101);
    end
    idle();
    check_all_z(4'b1111);

    // same-ID inc 5 + dec 2 merged -> 3, then dec 3 empties it
    drive(1'b1, 2'd2, 4'd5, 1'b1, 2'd2, 4'd2, 1'b1);
    check_all_z(4'b1011);
    idle();
    idle();
    check_all_z(4'b1011);
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 4'd3, 1'b1);
    check_all_z(4'b1011);
    idle();
    check_all_z(4'b1111);

    // zero-amount inc leaves the flag alone
    drive(1'b1, 2'd2, 4'd0, 1'b0, 2'd0, 4'd0, 1'b1);
    check_all_z(4'b1111);
    idle();
    check_all_z(4'b1111);

    // inc id0 blocks dec id3; dec then goes through and underflows
    drive(1'b1, 2'd0, 4'd2, 1'b1, 2'd3, 4'd1, 1'b0);
    exp_q.push_back({1'b0, 2'd3});
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 4'd1, 1'b1);
    idle();
    idle();
    check_all_z(4'b1110);
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 4'd2, 1'b1);
    idle();
    check_all_z(4'b1111);

    // 18 x inc 15 on id1: 17th reaches 255 exactly, 18th overflows and saturates
    for (int n = 1; n <= 18; n++) begin
      if (n == 18) exp_q.push_back({1'b1, 2'd1});
      drive(1'b1, 2'd1, 4'd15, 1'b0, 2'd0, 4'd0, 1'b1);
    end
    idle();
    idle();
    check_all_z(4'b1101);
    // 17 x dec 15 must land exactly on zero if the stored value is 255
    for (int n = 0; n < 17; n++) begin
      drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 4'd15, 1'b1);
    end
    check_all_z(4'b1101);
    idle();
    check_all_z(4'b1111);
    idle();
    idle();

    // load counters, then reset mid-stream, with a second reset mid-sweep
    drive(1'b1, 2'd0, 4'd5, 1'b0, 2'd0, 4'd0, 1'b1);
    drive(1'b1, 2'd3, 4'd7, 1'b0, 2'd0, 4'd0, 1'b1);
    idle();
    check_all_z(4'b0110);
    reset_n = 1'b0;
    #1;
    check("midrst_init_done", 32'(bus.o_init_done), 32'd0);
    check("midrst_inc_r", 32'(bus.i_inc_r), 32'd0);
    check_all_z(4'b1111);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("sweeprst_init_done", 32'(bus.o_init_done), 32'd0);
    release_and_sweep();

    // counters must be zero: a dec on id0 and id3 each underflows
    exp_q.push_back({1'b0, 2'd0});
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 4'd1, 1'b1);
    exp_q.push_back({1'b0, 2'd3});
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 4'd1, 1'b1);
    idle();
    idle();
    check_all_z(4'b1111);
    idle();
    idle();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
